// File: rtl/uart_axil_master_pkg.sv
// uart_axil_master_pkg
// Shared definitions for the UART command interpreter that acts as an AXI-Lite master.
// Contents: command opcodes, the bad-command response byte, the bridge FSM state type
// and a small opcode classification helper.
package uart_axil_master_pkg;

    localparam logic [7:0] CMD_WR       = 8'h57;
    localparam logic [7:0] CMD_RD       = 8'h52;
    localparam logic [7:0] RESP_BAD_CMD = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        AXI_AW_W,
        AXI_B,
        AXI_AR,
        AXI_R,
        TX_RESP
    } bridge_state_t;

    // True for the two opcodes the interpreter understands.
    function automatic logic is_known_cmd(input logic [7:0] opcode);
        return (opcode == CMD_WR) || (opcode == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_axil_master.sv
// uart_axil_master
// Byte-stream command interpreter acting as an AXI-Lite master. A host sends
// opcode + address (MSB first) + write data (MSB first, writes only); exactly one
// response frame is returned per command.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready         command bytes from the UART receiver
//   m_tdata/m_tvalid/m_tready         response bytes to the UART transmitter
//   m_aw*, m_w*, m_b*                 AXI-Lite write address / data / response channels
//   m_ar*, m_r*                       AXI-Lite read address / data channels
module uart_axil_master
    import uart_axil_master_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int FRAME_TIMEOUT   = 1_000_000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [7:0]                   s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [7:0]                   m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]                   m_awprot,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_wdata,
    output logic [3:0]                   m_wstrb,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    input  logic [1:0]                   m_bresp,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]                   m_arprot,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rvalid,
    output logic                         m_rready
);

    localparam int ADDR_BYTES = AXIL_ADDR_WIDTH / 8;
    localparam int DATA_BYTES = AXIL_DATA_WIDTH / 8;
    localparam int TW         = $clog2(FRAME_TIMEOUT + 1);
    localparam int RW         = AXIL_DATA_WIDTH + 8;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FRAME_TIMEOUT - 1);

    bridge_state_t              state, state_next;
    logic                       s_tready_q;
    logic                       byte_fire;
    logic [2:0]                 byte_cnt;
    logic                       is_write;
    logic [AXIL_ADDR_WIDTH-1:0] addr_q;
    logic [AXIL_DATA_WIDTH-1:0] data_q;
    logic [TW-1:0]              timeout_cnt;
    logic                       timeout_hit;
    logic                       aw_done_q, w_done_q;
    logic [RW-1:0]              resp_shift;
    logic [2:0]                 resp_left;
    logic                       addr_last, data_last;

    assign s_tready    = s_tready_q;
    assign byte_fire   = s_tvalid && s_tready_q;
    assign addr_last   = (byte_cnt == 3'(ADDR_BYTES - 1));
    assign data_last   = (byte_cnt == 3'(DATA_BYTES - 1));
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    // State register. s_tready is registered from the next state so it is already
    // low in the cycle after the last frame byte, which is what back-pressures the
    // host while the AXI transaction and the response are in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            s_tready_q <= 1'b0;
        end else begin
            state      <= state_next;
            s_tready_q <= (state_next == IDLE) || (state_next == RX_ADDR) ||
                          (state_next == RX_DATA);
        end
    end

    // Next-state logic. A byte arriving on the same edge the frame timer expires is
    // accepted and the frame continues; only an idle expiry discards the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (byte_fire) begin
                    state_next = is_known_cmd(s_tdata) ? RX_ADDR : TX_RESP;
                end
            end
            RX_ADDR: begin
                if (byte_fire) begin
                    if (addr_last) state_next = is_write ? RX_DATA : AXI_AR;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RX_DATA: begin
                if (byte_fire) begin
                    if (data_last) state_next = AXI_AW_W;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            AXI_AW_W: begin
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_next = AXI_B;
            end
            AXI_B:   if (m_bvalid)  state_next = TX_RESP;
            AXI_AR:  if (m_arready) state_next = AXI_R;
            AXI_R:   if (m_rvalid)  state_next = TX_RESP;
            TX_RESP: if (m_tready && (resp_left == 3'd1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. AW and W are each dropped as soon as their own handshake is
    // seen, tracked by the done flags, so the two channels can complete in any order.
    always_comb begin
        m_awaddr  = addr_q;
        m_araddr  = addr_q;
        m_wdata   = data_q;
        m_awprot  = 3'b000;
        m_arprot  = 3'b000;
        m_wstrb   = 4'hF;
        m_awvalid = (state == AXI_AW_W) && !aw_done_q;
        m_wvalid  = (state == AXI_AW_W) && !w_done_q;
        m_bready  = (state == AXI_B);
        m_arvalid = (state == AXI_AR);
        m_rready  = (state == AXI_R);
        m_tvalid  = (state == TX_RESP);
        m_tdata   = resp_shift[RW-1 -: 8];
    end

    // Frame datapath: address/data shift registers, byte and inter-byte timers,
    // AW/W completion flags and the response shift register (sent MSB byte first).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt    <= '0;
            is_write    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            timeout_cnt <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_shift  <= '0;
            resp_left   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt    <= '0;
                    timeout_cnt <= '0;
                    if (byte_fire) begin
                        is_write <= (s_tdata == CMD_WR);
                        if (!is_known_cmd(s_tdata)) begin
                            resp_shift <= {RESP_BAD_CMD, {AXIL_DATA_WIDTH{1'b0}}};
                            resp_left  <= 3'd1;
                        end
                    end
                end
                RX_ADDR, RX_DATA: begin
                    if (byte_fire) begin
                        timeout_cnt <= '0;
                        if (state == RX_ADDR) begin
                            addr_q   <= (addr_q << 8) | AXIL_ADDR_WIDTH'(s_tdata);
                            byte_cnt <= addr_last ? 3'd0 : byte_cnt + 3'd1;
                        end else begin
                            data_q   <= (data_q << 8) | AXIL_DATA_WIDTH'(s_tdata);
                            byte_cnt <= data_last ? 3'd0 : byte_cnt + 3'd1;
                            if (data_last) begin
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                            end
                        end
                    end else if (timeout_hit) begin
                        timeout_cnt <= '0;
                        byte_cnt    <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                AXI_AW_W: begin
                    if (m_awvalid && m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
                end
                AXI_B: begin
                    if (m_bvalid) begin
                        resp_shift <= {6'b0, m_bresp, {AXIL_DATA_WIDTH{1'b0}}};
                        resp_left  <= 3'd1;
                    end
                end
                AXI_R: begin
                    if (m_rvalid) begin
                        resp_shift <= {6'b0, m_rresp, m_rdata};
                        resp_left  <= 3'(1 + DATA_BYTES);
                    end
                end
                TX_RESP: begin
                    if (m_tready) begin
                        resp_shift <= resp_shift << 8;
                        resp_left  <= resp_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_master.sv
// tb_uart_axil_master
// Self-checking bench: a host driver sends command frames, a behavioural AXI-Lite
// slave answers them, a receiver collects response bytes, and a reference model
// (memory array + expected byte queues) predicts every response.
module tb_uart_axil_master;

    localparam int FT = 40;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_axil_master #(
        .AXIL_ADDR_WIDTH(32),
        .AXIL_DATA_WIDTH(32),
        .FRAME_TIMEOUT  (FT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_awaddr (m_awaddr),
        .m_awprot (m_awprot),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_bresp  (m_bresp),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .m_araddr (m_araddr),
        .m_arprot (m_arprot),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave configuration, logs and timing stamps
    int          aw_wait_cfg = 0, w_wait_cfg = 0, r_wait_cfg = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    logic [3:0]  strb_log[$];
    logic [2:0]  prot_log[$];
    int          aw_rise_cyc, w_rise_cyc, ar_rise_cyc;
    int          aw_hs_cyc, w_hs_cyc, b_hs_cyc, r_hs_cyc;
    int          last_acc_cyc, tv_rise_cyc;
    logic        rand_ready = 1'b0;
    byte_q_t     rx_q;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Behavioural AXI-Lite slave. Decisions are taken on the falling edge; a
    // handshake completes on the following rising edge.
    initial begin : slave
        logic aw_got, w_got, ar_got, b_fire, r_fire, aw_seen, w_seen, ar_seen;
        int aw_cnt, w_cnt, r_cnt;
        logic [31:0] aw_addr, w_data, ar_addr;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        aw_addr = 0; w_data = 0; ar_addr = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
                continue;
            end
            if (b_fire) begin
                m_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
                aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
            end
            if (r_fire) begin
                m_rvalid = 0; r_fire = 0; ar_got = 0; ar_seen = 0; r_cnt = 0;
            end
            if (m_awvalid && !aw_seen) begin aw_seen = 1; aw_rise_cyc = cyc; end
            if (m_wvalid && !w_seen)   begin w_seen = 1;  w_rise_cyc = cyc;  end
            if (m_arvalid && !ar_seen) begin ar_seen = 1; ar_rise_cyc = cyc; end
            if (aw_got && w_got && !m_bvalid && !b_fire) begin
                if (bresp_cfg == 2'b00) slave_mem[aw_addr] = w_data;
                m_bresp  = bresp_cfg;
                m_bvalid = 1;
            end
            if (m_bvalid && m_bready && !b_fire) begin b_fire = 1; b_hs_cyc = cyc + 1; end
            m_awready = 0;
            if (m_awvalid && !aw_got) begin
                if (aw_cnt >= aw_wait_cfg) begin
                    m_awready = 1; aw_got = 1; aw_addr = m_awaddr; aw_hs_cyc = cyc + 1;
                    aw_log.push_back(m_awaddr); prot_log.push_back(m_awprot);
                end else aw_cnt++;
            end
            m_wready = 0;
            if (m_wvalid && !w_got) begin
                if (w_cnt >= w_wait_cfg) begin
                    m_wready = 1; w_got = 1; w_data = m_wdata; w_hs_cyc = cyc + 1;
                    w_log.push_back(m_wdata); strb_log.push_back(m_wstrb);
                end else w_cnt++;
            end
            if (ar_got && !m_rvalid && !r_fire) begin
                if (r_cnt >= r_wait_cfg) begin
                    m_rdata  = slave_mem.exists(ar_addr) ? slave_mem[ar_addr] : dflt(ar_addr);
                    m_rresp  = rresp_cfg;
                    m_rvalid = 1;
                end else r_cnt++;
            end
            if (m_rvalid && m_rready && !r_fire) begin r_fire = 1; r_hs_cyc = cyc + 1; end
            m_arready = 0;
            if (m_arvalid && !ar_got) begin
                m_arready = 1; ar_got = 1; ar_addr = m_araddr;
                ar_log.push_back(m_araddr); prot_log.push_back(m_arprot);
            end
        end
    end

    // Response receiver with optional random back-pressure.
    initial begin : receiver
        logic tv_prev;
        tv_prev = 0;
        m_tready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin m_tready = 0; tv_prev = 0; continue; end
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_tvalid && !tv_prev) tv_rise_cyc = cyc;
            tv_prev = m_tvalid;
            if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = b;
        n = 0;
        while (!s_tready && n < 500) begin @(negedge clk); n++; end
        if (!s_tready) begin
            total++; bad++;
            $display("[TB] FAIL send_byte: s_tready=%b after %0d cycles, required 1", s_tready, n);
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t fr, input int max_gap);
        foreach (fr[i]) send_byte(fr[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 3000) begin @(negedge clk); k++; end
        repeat (8) @(negedge clk);
    endtask

    function automatic byte_q_t wr_frame(input logic [31:0] a, input logic [31:0] d);
        return '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
    endfunction

    function automatic byte_q_t rd_frame(input logic [31:0] a);
        return '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
    endfunction

    function automatic byte_q_t rd_resp(input logic [1:0] r, input logic [31:0] d);
        return '{{6'b0, r}, d[31:24], d[23:16], d[15:8], d[7:0]};
    endfunction

    function automatic logic same_bytes(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        rx_q.delete(); aw_log.delete(); w_log.delete(); ar_log.delete();
        strb_log.delete(); prot_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({s_tready, m_tvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b required 0000000",
                     {s_tready, m_tvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        total++;
        if (m_awaddr !== 32'h0 || m_araddr !== 32'h0 || m_wdata !== 32'h0 || m_tdata !== 8'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: awaddr=%h araddr=%h wdata=%h tdata=%h required all 0",
                     m_awaddr, m_araddr, m_wdata, m_tdata);
        end
        total++;
        if (m_awprot !== 3'b000 || m_arprot !== 3'b000 || m_wstrb !== 4'hF) begin
            bad++;
            $display("[TB] FAIL fixed_sidebands: awprot=%b arprot=%b wstrb=%h required 000 000 f",
                     m_awprot, m_arprot, m_wstrb);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", s_tready);
        end
    endtask

    task automatic test_write();
        clear_logs();
        aw_wait_cfg = 0; w_wait_cfg = 0; bresp_cfg = 2'b00;
        send_frame(wr_frame(32'h10, 32'hDEADBEEF), 0);
        ref_mem[32'h10] = 32'hDEADBEEF;
        wait_resp(1);
        total++;
        if (aw_log.size() != 1 || aw_log[0] !== 32'h10 || w_log.size() != 1 ||
            w_log[0] !== 32'hDEADBEEF || strb_log[0] !== 4'hF || prot_log[0] !== 3'b000) begin
            bad++;
            $display("[TB] FAIL write_axi: aw=%p w=%p strb=%p required aw 10 w deadbeef strb f",
                     aw_log, w_log, strb_log);
        end
        total++;
        if (aw_rise_cyc != last_acc_cyc || w_rise_cyc != last_acc_cyc) begin
            bad++;
            $display("[TB] FAIL write_valid_latency: aw at %0d w at %0d required %0d",
                     aw_rise_cyc, w_rise_cyc, last_acc_cyc);
        end
        total++;
        if (!same_bytes(rx_q, '{8'h00})) begin
            bad++;
            $display("[TB] FAIL write_resp: got %p required '{00}", rx_q);
        end
        total++;
        if (tv_rise_cyc != b_hs_cyc) begin
            bad++;
            $display("[TB] FAIL write_resp_latency: tvalid at %0d required %0d", tv_rise_cyc, b_hs_cyc);
        end
    endtask

    task automatic test_read();
        clear_logs();
        slave_mem[32'h20] = 32'h12345678;
        ref_mem[32'h20]   = 32'h12345678;
        rresp_cfg = 2'b00; r_wait_cfg = 0;
        send_frame(rd_frame(32'h20), 0);
        wait_resp(5);
        total++;
        if (ar_log.size() != 1 || ar_log[0] !== 32'h20 || prot_log[0] !== 3'b000) begin
            bad++;
            $display("[TB] FAIL read_axi: ar=%p required '{20}", ar_log);
        end
        total++;
        if (ar_rise_cyc != last_acc_cyc) begin
            bad++;
            $display("[TB] FAIL read_valid_latency: ar at %0d required %0d", ar_rise_cyc, last_acc_cyc);
        end
        total++;
        if (!same_bytes(rx_q, '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78})) begin
            bad++;
            $display("[TB] FAIL read_resp: got %p required 00 12 34 56 78", rx_q);
        end
        total++;
        if (tv_rise_cyc != r_hs_cyc) begin
            bad++;
            $display("[TB] FAIL read_resp_latency: tvalid at %0d required %0d", tv_rise_cyc, r_hs_cyc);
        end
    endtask

    task automatic test_bad_cmd();
        clear_logs();
        send_frame('{8'h41}, 0);
        wait_resp(1);
        total++;
        if (!same_bytes(rx_q, '{8'hEE}) || aw_log.size() != 0 || ar_log.size() != 0) begin
            bad++;
            $display("[TB] FAIL bad_cmd: got %p aw=%0d ar=%0d required '{ee} and no AXI",
                     rx_q, aw_log.size(), ar_log.size());
        end
        clear_logs();
        send_frame(rd_frame(32'h20), 0);
        wait_resp(5);
        total++;
        if (!same_bytes(rx_q, rd_resp(2'b00, ref_mem[32'h20]))) begin
            bad++;
            $display("[TB] FAIL read_after_bad_cmd: got %p required 00 12 34 56 78", rx_q);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_frame('{8'h57, 8'h00, 8'h00}, 0);
        repeat (FT + 10) @(negedge clk);
        total++;
        if (rx_q.size() != 0 || aw_log.size() != 0 || ar_log.size() != 0 || s_tready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_discard: rx=%p aw=%0d ar=%0d tready=%b required none none none 1",
                     rx_q, aw_log.size(), ar_log.size(), s_tready);
        end
        clear_logs();
        send_frame('{8'h52, 8'h00, 8'h00, 8'h00}, 0);
        send_byte(8'h10, FT - 1);
        wait_resp(5);
        total++;
        if (!same_bytes(rx_q, rd_resp(2'b00, ref_mem[32'h10])) || ar_log.size() != 1) begin
            bad++;
            $display("[TB] FAIL timeout_edge_byte_wins: got %p ar=%p required 00 de ad be ef", rx_q, ar_log);
        end
        clear_logs();
        send_frame(wr_frame(32'h24, 32'hCAFE0001), 0);
        ref_mem[32'h24] = 32'hCAFE0001;
        wait_resp(1);
        total++;
        if (!same_bytes(rx_q, '{8'h00}) || aw_log.size() != 1 || aw_log[0] !== 32'h24 ||
            w_log[0] !== 32'hCAFE0001) begin
            bad++;
            $display("[TB] FAIL write_after_timeout: got %p aw=%p w=%p required 00 24 cafe0001",
                     rx_q, aw_log, w_log);
        end
    endtask

    task automatic test_aw_delay();
        clear_logs();
        aw_wait_cfg = 5; w_wait_cfg = 0; bresp_cfg = 2'b10;
        send_frame(wr_frame(32'h30, 32'h0BADF00D), 0);
        wait_resp(1);
        total++;
        if (!(w_hs_cyc < aw_hs_cyc) || aw_log.size() != 1 || aw_log[0] !== 32'h30 ||
            w_log[0] !== 32'h0BADF00D) begin
            bad++;
            $display("[TB] FAIL aw_delay_order: w hs %0d aw hs %0d aw=%p w=%p required w first, 30, 0badf00d",
                     w_hs_cyc, aw_hs_cyc, aw_log, w_log);
        end
        total++;
        if (!same_bytes(rx_q, '{8'h02})) begin
            bad++;
            $display("[TB] FAIL aw_delay_resp: got %p required '{02}", rx_q);
        end
        aw_wait_cfg = 0; bresp_cfg = 2'b00;
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            int          op;
            logic [31:0] a, d;
            logic [7:0]  opc;
            byte_q_t     exp;
            clear_logs();
            op = $urandom_range(0, 9);
            a  = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            d  = $urandom;
            aw_wait_cfg = $urandom_range(0, 3); w_wait_cfg = $urandom_range(0, 3);
            r_wait_cfg  = $urandom_range(0, 3);
            bresp_cfg   = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            rresp_cfg   = 2'($urandom_range(0, 3));
            if (op < 4) begin
                send_frame(wr_frame(a, d), 2);
                exp = '{{6'b0, bresp_cfg}};
                if (bresp_cfg == 2'b00) ref_mem[a] = d;
            end else if (op < 8) begin
                send_frame(rd_frame(a), 2);
                exp = rd_resp(rresp_cfg, ref_mem.exists(a) ? ref_mem[a] : dflt(a));
            end else begin
                do opc = 8'($urandom_range(0, 255)); while (opc == 8'h57 || opc == 8'h52);
                send_frame('{opc}, 0);
                exp = '{8'hEE};
            end
            wait_resp(exp.size());
            total++;
            if (!same_bytes(rx_q, exp)) begin
                bad++;
                $display("[TB] FAIL rand_resp cmd %0d op %0d: got %p required %p", k, op, rx_q, exp);
            end
            if (op < 4) begin
                total++;
                if (aw_log.size() != 1 || aw_log[0] !== a || w_log.size() != 1 || w_log[0] !== d) begin
                    bad++;
                    $display("[TB] FAIL rand_write_axi cmd %0d: aw=%p w=%p required %h %h", k, aw_log, w_log, a, d);
                end
            end else if (op < 8) begin
                total++;
                if (ar_log.size() != 1 || ar_log[0] !== a) begin
                    bad++;
                    $display("[TB] FAIL rand_read_axi cmd %0d: ar=%p required %h", k, ar_log, a);
                end
            end
        end
        aw_wait_cfg = 0; w_wait_cfg = 0; r_wait_cfg = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        rand_ready = 1'b1;
        r_wait_cfg = 30;
        send_frame(rd_frame(32'h44), 0);
        n = 0;
        while (!m_rready && n < 100) begin @(negedge clk); n++; end
        total++;
        if (m_rready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reach_axi_r: rready=%b after %0d cycles required 1", m_rready, n);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({s_tready, m_tvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'b0 ||
            m_awaddr !== 32'h0 || m_wdata !== 32'h0 || m_tdata !== 8'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs: ctrl=%b awaddr=%h wdata=%h tdata=%h required all 0",
                     {s_tready, m_tvalid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
                     m_awaddr, m_wdata, m_tdata);
        end
        @(negedge clk);
        rst = 1'b0;
        r_wait_cfg = 0;
        repeat (3) @(negedge clk);
        total++;
        if (rx_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL abandoned_read_resp: got %p required none", rx_q);
        end
        clear_logs();
        send_frame(rd_frame(32'h10), 0);
        wait_resp(5);
        total++;
        if (!same_bytes(rx_q, rd_resp(2'b00, ref_mem[32'h10]))) begin
            bad++;
            $display("[TB] FAIL read_after_reset: got %p required 00 de ad be ef", rx_q);
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        rst      = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_aw_delay();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
